// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute stage.
//   alu_op_t : 3-bit ALU operation code (ADD..SLT)
//   PC_STEP  : byte distance to the sequential next instruction
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational integer ALU.
// Ports:
//   a, b    in  WIDTH : operands (b may be an immediate)
//   alu_sel in  3     : operation code (alu_op_t)
//   y       out WIDTH : result; adds/subtracts wrap modulo 2^WIDTH
//   zero    out 1     : 1 when y == 0
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_sel,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   shamt;

    assign a_s   = a;
    assign b_s   = b;
    // Only the low log2(WIDTH) bits of b select the shift distance.
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (alu_sel)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/exec_alu_unit.sv
// exec_alu_unit: registered execute stage (ALU + next-PC + branch-target adders).
// Ports:
//   clk           in  1     : rising-edge clock
//   rst           in  1     : asynchronous active-low reset
//   in_valid      in  1     : operands/alu_sel valid this cycle
//   alu_sel       in  3     : ALU operation code
//   a, b          in  WIDTH : forwarded ALU operands
//   pc            in  WIDTH : instruction PC
//   imm           in  WIDTH : sign-extended branch immediate
//   result        out WIDTH : registered ALU result
//   zero          out 1     : registered result==0 flag
//   pc_plus4      out WIDTH : registered pc + 4
//   branch_target out WIDTH : registered pc + (imm << 1)
//   out_valid     out 1     : outputs hold a newly captured result
module exec_alu_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             out_valid
);

    logic [WIDTH-1:0] alu_y_p0;
    logic             alu_zero_p0;
    logic [WIDTH-1:0] pc_plus4_p0;
    logic [WIDTH-1:0] branch_target_p0;

    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;
    logic [WIDTH-1:0] pc_plus4_p1;
    logic [WIDTH-1:0] branch_target_p1;
    logic             vld_p1;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (a),
        .b       (b),
        .alu_sel (alu_op_t'(alu_sel)),
        .y       (alu_y_p0),
        .zero    (alu_zero_p0)
    );

    assign pc_plus4_p0      = pc + WIDTH'(PC_STEP);
    // Shifting drops imm's MSB; the sum wraps naturally at WIDTH bits.
    assign branch_target_p0 = pc + {imm[WIDTH-2:0], 1'b0};

    // Stage boundary p0 -> p1: output register bank.
    // Data holds when no new input arrives; reset value keeps zero consistent with result=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_p1        <= '0;
            zero_p1          <= 1'b1;
            pc_plus4_p1      <= '0;
            branch_target_p1 <= '0;
            vld_p1           <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                result_p1        <= alu_y_p0;
                zero_p1          <= alu_zero_p0;
                pc_plus4_p1      <= pc_plus4_p0;
                branch_target_p1 <= branch_target_p0;
            end
        end
    end

    assign result        = result_p1;
    assign zero          = zero_p1;
    assign pc_plus4      = pc_plus4_p1;
    assign branch_target = branch_target_p1;
    assign out_valid     = vld_p1;

endmodule

// File: tb/tb_exec_alu_unit.sv
module tb_exec_alu_unit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [2:0]   alu_sel = '0;
    logic [W-1:0] a = '0, b = '0, pc = '0, imm = '0;
    logic [W-1:0] result, pc_plus4, branch_target;
    logic         zero, out_valid;

    exec_alu_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .alu_sel       (alu_sel),
        .a             (a),
        .b             (b),
        .pc            (pc),
        .imm           (imm),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a, b, pc, imm;
        logic [W-1:0] res;
        logic         z;
        logic [W-1:0] pc4, bt;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic [W-1:0] pc4, bt;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int total = 0;
    int bad = 0;

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    vec_t vecs[14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every output cycle must match the oldest captured expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 || sb_q.size() > 0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", W'(out_valid), W'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_valid", W'(out_valid), W'(1));
                check("result", result, e.res);
                check("zero", W'(zero), W'(e.z));
                check("pc_plus4", pc_plus4, e.pc4);
                check("branch_target", branch_target, e.bt);
            end
        end
    end

    // Drive one valid op; the expectation is queued once the capturing edge passes.
    task automatic issue(input vec_t v);
        exp_t e;
        in_valid = 1'b1;
        alu_sel  = v.sel;
        a = v.a; b = v.b; pc = v.pc; imm = v.imm;
        @(posedge clk);
        if (rst) begin
            e.res = v.res; e.z = v.z; e.pc4 = v.pc4; e.bt = v.bt;
            sb_q.push_back(e);
            last_exp = e;
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); pc = W'($urandom); imm = W'($urandom);
        alu_sel = 3'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_result"}, result, '0);
        check({tag, "_zero"}, W'(zero), W'(1));
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_pc_plus4"}, pc_plus4, '0);
        check({tag, "_branch_target"}, branch_target, '0);
    endtask

    initial begin
        //          sel     a                      b                      pc           imm                    res                    z     pc4          bt
        vecs[0]  = '{3'b000, W'(5),                W'(7),                 W'('h100),   W'(8),                 W'(12),                1'b0, W'('h104),   W'('h110)};
        vecs[1]  = '{3'b001, W'(9),                W'(9),                 W'('h100),   ONES - W'(3),          W'(0),                 1'b1, W'('h104),   W'('hF8)};
        vecs[2]  = '{3'b000, ONES,                 W'(1),                 ONES,        W'(0),                 W'(0),                 1'b1, W'(3),       ONES};
        vecs[3]  = '{3'b010, W'('hF0F0),           W'('h0FF0),            W'(0),       W'(0),                 W'('h00F0),            1'b0, W'(4),       W'(0)};
        vecs[4]  = '{3'b011, W'('hF0F0),           W'('h0FF0),            W'('h1000),  W'('h10),              W'('hFFF0),            1'b0, W'('h1004),  W'('h1020)};
        vecs[5]  = '{3'b100, W'('hF0F0),           W'('h0FF0),            W'('h8),     W'(1),                 W'('hFF00),            1'b0, W'('hC),     W'('hA)};
        vecs[6]  = '{3'b101, W'(1),                W'(63),                W'('h200),   W'('h80),              MSB,                   1'b0, W'('h204),   W'('h300)};
        vecs[7]  = '{3'b110, MSB,                  W'('h43),              W'(0),       MSB | W'(1),           W'('h1000_0000_0000_0000), 1'b0, W'(4),   W'(2)};
        vecs[8]  = '{3'b111, ONES,                 W'(1),                 W'('h40),    W'(0),                 W'(1),                 1'b0, W'('h44),    W'('h40)};
        vecs[9]  = '{3'b111, W'(1),                ONES,                  W'('h40),    W'(0),                 W'(0),                 1'b1, W'('h44),    W'('h40)};
        vecs[10] = '{3'b111, W'(7),                W'(7),                 W'('h40),    W'(0),                 W'(0),                 1'b1, W'('h44),    W'('h40)};
        vecs[11] = '{3'b001, W'(3),                W'(5),                 W'('h10),    W'(2),                 ONES - W'(1),          1'b0, W'('h14),    W'('h14)};
        vecs[12] = '{3'b111, W'(5),                W'(9),                 W'(0),       W'(0),                 W'(1),                 1'b0, W'(4),       W'(0)};
        vecs[13] = '{3'b110, W'('hFF),             W'(4),                 W'(0),       W'(0),                 W'('h0F),              1'b0, W'(4),       W'(0)};

        // Reset held for two cycles with live, valid-looking inputs.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); pc = W'($urandom); imm = W'($urandom);
            alu_sel = 3'($urandom);
            @(posedge clk);
            #1;
            check_reset_state("rst_hold");
        end
        in_valid = 1'b0;
        rst = 1'b1;
        idle();

        // Back-to-back stream of all vectors.
        for (int i = 0; i < 14; i++) issue(vecs[i]);

        // Two idle cycles: out_valid drops, last values are held.
        for (int i = 0; i < 2; i++) begin
            idle();
            check("idle_out_valid", W'(out_valid), W'(0));
            check("hold_result", result, last_exp.res);
            check("hold_zero", W'(zero), W'(last_exp.z));
            check("hold_pc_plus4", pc_plus4, last_exp.pc4);
            check("hold_branch_target", branch_target, last_exp.bt);
        end

        // Mid-stream reset: outputs clear immediately, in-flight op discarded.
        issue(vecs[0]);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        alu_sel = vecs[3].sel; a = vecs[3].a; b = vecs[3].b; pc = vecs[3].pc; imm = vecs[3].imm;
        rst = 1'b0;
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("rst_midstream");
        rst = 1'b1;
        in_valid = 1'b0;
        idle();
        check("post_rst_out_valid", W'(out_valid), W'(0));

        // First capture after reset release.
        issue(vecs[5]);
        idle();
        idle();
        check("scoreboard_drained", W'(sb_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
